wb_mailbox_subordinate: RTL and testbench
=========================================

Name: wb_mailbox_subordinate

Overview:
- Wishbone subordinate (responder) peripheral that sits behind the wishbone decoder on one peripheral slot.
- Gives the CPU-side manager a two-way mailbox to a user design. A TX FIFO carries words from the bus to the design; an RX FIFO carries words from the design to the bus.
- Also provides status, control and scratch registers, and raises an interrupt when RX data is pending.

Parameters:
- DEPTH, 8, entries per FIFO; power of 2, range 2..32.
- WAIT_STATES, 0, extra cycles inserted before each ack; range 0..15.

Ports:
- wb_clk_i  in  1  the single clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte lane selects.
- wbs_adr_i  in  32  address; only bits [4:2] are decoded.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- tx_dat_o  out  32  TX FIFO head word.
- tx_valid_o  out  1  TX FIFO not empty.
- tx_ready_i  in  1  design pops TX when tx_valid_o & tx_ready_i.
- rx_dat_i  in  32  design word to push into RX.
- rx_valid_i  in  1  design offers a word.
- rx_ready_o  out  1  RX can accept a word; a push happens when rx_valid_i & rx_ready_o.
- irq_o  out  1  interrupt.

Behaviour:
- Reset (wb_rst_i=1 at a rising edge):
  - wbs_ack_o=0, wbs_dat_o=0, tx_valid_o=0, rx_ready_o=0, irq_o=0.
  - FIFOs emptied; sticky flags, CTRL and SCRATCH cleared.
  - A reset mid-transfer aborts it with no side effect and no ack.
- Register map, word offsets by adr[4:2]:
  - 0x00 TXDATA: write-only; a write pushes one word. Unselected byte lanes are pushed as 0x00. Reads return 0.
  - 0x04 RXDATA: read-only; a read pops the head word. Writes are ignored.
  - 0x08 STATUS: read-only.
    - [5:0] tx_count, [13:8] rx_count.
    - [16] tx_full, [17] tx_empty, [18] rx_full, [19] rx_empty.
    - [20] tx_ovf (sticky), [21] rx_unf (sticky).
    - Other bits 0.
  - 0x0C CTRL:
    - [0] tx_flush and [1] rx_flush: write-1 pulse, read as 0.
    - [2] irq_en: read/write.
    - [3] clr_sticky: write-1 pulse, read as 0.
  - 0x10 SCRATCH: read/write; wbs_sel_i masks the write per byte.
  - 0x14..0x1C: reads return 0, writes ignored; these are still acked.
- Handshake FSM with states IDLE, WAIT, ACK:
  - IDLE: on cyc&stb, latch we/adr/sel/dat. Go to WAIT if WAIT_STATES>0, else go to ACK.
  - WAIT: count WAIT_STATES cycles, then go to ACK. If cyc drops, return to IDLE with no side effect.
  - ACK: wbs_ack_o=1 for exactly one cycle, then IDLE. ack is never asserted on consecutive cycles.
  - Latency: ack is high WAIT_STATES+1 cycles after the edge that sampled the request.
  - Back-to-back transfers are separated by at least one IDLE cycle.
- Side effects (push, pop, register write, flush) commit on the edge that raises wbs_ack_o. wbs_dat_o is registered on the same edge and held until the next ack. An aborted transfer therefore never pushes or pops.
- TXDATA write while tx_full: word dropped, tx_ovf set, ack still given.
- RXDATA read while rx_empty: returns 0x0000_0000, rx_unf set, ack given.
- Sticky flag precedence: a clr_sticky and a new overflow/underflow on the same edge leave the flag set.
- FIFO rules:
  - Full/empty are evaluated at the start of the cycle; a push to a full FIFO is refused even if a pop happens on the same edge.
  - A push and a pop on the same edge of a non-empty, non-full FIFO leave the count unchanged.
  - Pointers wrap modulo DEPTH. Counts run 0..DEPTH.
- tx_dat_o is the combinational head value; it is only meaningful while tx_valid_o=1.
- rx_ready_o = ~rx_full & ~wb_rst_i.
- Flush beats push on the same edge: a word accepted by the design that edge is dropped. A bus pop in the same cycle cannot occur because flush is itself a bus write.
- irq_o is registered: irq_o <= irq_en & ~rx_empty.

Test Plan:
- Reset, then a SCRATCH write of 0x12345678 with sel=4'hF, then a sel=4'b0011 write of 0xAAAAAAAA, then a read -> read returns 0x1234AAAA; ack is exactly 1 cycle, WAIT_STATES+1 cycles after the request.
- Push 0xDEADBEEF and 0x00C0FFEE to TXDATA with tx_ready_i=0 -> STATUS[5:0]=2, tx_dat_o=0xDEADBEEF. Raise tx_ready_i for 2 cycles -> both words emerge in order, then tx_valid_o=0.
- Design pushes 8 words 1..8 (DEPTH=8) -> rx_ready_o drops after the 8th; a 9th offer is not taken. Bus reads RXDATA 9 times -> 1..8 then 0, with STATUS[21]=1.
- TX full, then a TXDATA write of 0x55 -> ack given, tx_count stays 8, STATUS[20]=1. Write CTRL=0x8 -> STATUS[21:20]=0.
- With WAIT_STATES=3, drop cyc in the 2nd wait cycle of a TXDATA write -> no ack, tx_count unchanged. Assert reset mid-WAIT -> ack stays 0 and all counts read 0.
- With irq_en=1, the design pushes one word -> irq_o rises 1 cycle later. Write CTRL=0x6 -> rx_count=0 and irq_o falls the next cycle.

Source files
------------

// File: rtl/wb_mailbox_subordinate.sv
// Wishbone mailbox peripheral: a TX FIFO from bus to user design, an RX FIFO
// from user design to bus, plus STATUS/CTRL/SCRATCH registers and an RX irq.
module wb_mailbox_subordinate #(
  parameter int DEPTH       = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] tx_dat_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [31:0] rx_dat_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  logic        we_reg;
  logic [2:0]  adr_reg;
  logic [3:0]  sel_reg;
  logic [31:0] dat_reg;

  logic        cur_we;
  logic [2:0]  cur_adr;
  logic [3:0]  cur_sel;
  logic [31:0] cur_dat;
  logic [31:0] sel_mask;
  logic        commit;

  logic [31:0] tx_mem [DEPTH];
  logic [31:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg, rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [CW-1:0] tx_cnt_reg, rx_cnt_reg;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_ovf_reg, rx_unf_reg, irq_en_reg, irq_reg;
  logic [31:0] scratch_reg, rd_data, dat_out_reg;

  logic        wr_tx, rd_rx, wr_ctrl, wr_scr;
  logic        tx_flush, rx_flush, clr_sticky;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic        adr_unused;

  assign adr_unused = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

  // Handshake state register and latched request fields
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      we_reg       <= 1'b0;
      adr_reg      <= '0;
      sel_reg      <= '0;
      dat_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_reg == IDLE && wbs_cyc_i && wbs_stb_i) begin
        we_reg  <= wbs_we_i;
        adr_reg <= wbs_adr_i[4:2];
        sel_reg <= wbs_sel_i;
        dat_reg <= wbs_dat_i;
      end
    end
  end

  // Next-state logic: IDLE -> (WAIT x WAIT_STATES) -> ACK -> IDLE; cyc drop aborts WAIT
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          wait_cnt_next = '0;
          state_next    = (WAIT_STATES == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!wbs_cyc_i)                   state_next = IDLE;
        else if (wait_cnt_reg == WAIT_LAST) state_next = ACK;
        else                              wait_cnt_next = wait_cnt_reg + 4'd1;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With zero wait states the request commits on the very edge that samples it,
  // so the live bus fields are used while still in IDLE.
  assign cur_we  = (state_reg == IDLE) ? wbs_we_i        : we_reg;
  assign cur_adr = (state_reg == IDLE) ? wbs_adr_i[4:2]  : adr_reg;
  assign cur_sel = (state_reg == IDLE) ? wbs_sel_i       : sel_reg;
  assign cur_dat = (state_reg == IDLE) ? wbs_dat_i       : dat_reg;
  assign commit  = ~wb_rst_i && (state_next == ACK) && (state_reg != ACK);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign sel_mask[gi*8 +: 8] = {8{cur_sel[gi]}};
    end
  endgenerate

  assign wr_tx      = commit &  cur_we & (cur_adr == 3'd0);
  assign rd_rx      = commit & ~cur_we & (cur_adr == 3'd1);
  assign wr_ctrl    = commit &  cur_we & (cur_adr == 3'd3);
  assign wr_scr     = commit &  cur_we & (cur_adr == 3'd4);
  assign tx_flush   = wr_ctrl & cur_dat[0];
  assign rx_flush   = wr_ctrl & cur_dat[1];
  assign clr_sticky = wr_ctrl & cur_dat[3];

  assign tx_full    = (tx_cnt_reg == CW'(DEPTH));
  assign tx_empty   = (tx_cnt_reg == '0);
  assign rx_full    = (rx_cnt_reg == CW'(DEPTH));
  assign rx_empty   = (rx_cnt_reg == '0);

  assign tx_push    = wr_tx & ~tx_full;
  assign tx_pop     = ~tx_empty & tx_ready_i;
  assign rx_ready_o = ~rx_full & ~wb_rst_i;
  assign rx_push    = rx_valid_i & rx_ready_o;
  assign rx_pop     = rd_rx & ~rx_empty;

  assign tx_valid_o = ~tx_empty;
  assign tx_dat_o   = tx_mem[tx_rd_ptr_reg];

  // FIFO storage arrays (no reset needed; occupancy is tracked by the counters)
  always_ff @(posedge wb_clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= cur_dat & sel_mask;
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= rx_dat_i;
  end

  // FIFO pointers and counts; flush overrides any push/pop on the same edge
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || tx_flush) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_cnt_reg    <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + AW'(1);
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_reg <= tx_cnt_reg + CW'(1);
        2'b01:   tx_cnt_reg <= tx_cnt_reg - CW'(1);
        default: tx_cnt_reg <= tx_cnt_reg;
      endcase
    end
    if (wb_rst_i || rx_flush) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_cnt_reg    <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + AW'(1);
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_reg <= rx_cnt_reg + CW'(1);
        2'b01:   rx_cnt_reg <= rx_cnt_reg - CW'(1);
        default: rx_cnt_reg <= rx_cnt_reg;
      endcase
    end
  end

  // Read data mux for the committing transfer
  always_comb begin
    rd_data = '0;
    case (cur_adr)
      3'd1: rd_data = rx_empty ? 32'h0 : rx_mem[rx_rd_ptr_reg];
      3'd2: rd_data = {10'b0, rx_unf_reg, tx_ovf_reg, rx_empty, rx_full, tx_empty, tx_full,
                       2'b0, 6'(rx_cnt_reg), 2'b0, 6'(tx_cnt_reg)};
      3'd3: rd_data = {29'b0, irq_en_reg, 2'b0};
      3'd4: rd_data = scratch_reg;
      default: rd_data = '0;
    endcase
  end

  // Control/status registers, sticky flags (set wins over clear), irq and read data
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tx_ovf_reg  <= 1'b0;
      rx_unf_reg  <= 1'b0;
      irq_en_reg  <= 1'b0;
      scratch_reg <= '0;
      irq_reg     <= 1'b0;
      dat_out_reg <= '0;
    end else begin
      tx_ovf_reg <= (tx_ovf_reg & ~clr_sticky) | (wr_tx & tx_full);
      rx_unf_reg <= (rx_unf_reg & ~clr_sticky) | (rd_rx & rx_empty);
      if (wr_ctrl) irq_en_reg  <= cur_dat[2];
      if (wr_scr)  scratch_reg <= (scratch_reg & ~sel_mask) | (cur_dat & sel_mask);
      irq_reg <= irq_en_reg & ~rx_empty;
      if (commit)  dat_out_reg <= cur_we ? 32'h0 : rd_data;
    end
  end

  assign wbs_ack_o = (state_reg == ACK);
  assign wbs_dat_o = dat_out_reg;
  assign irq_o     = irq_reg;

endmodule

// File: tb/tb_wb_mailbox_subordinate.sv
// Directed bench for wb_mailbox_subordinate (DEPTH=8, WAIT_STATES=3).
module tb_wb_mailbox_subordinate;

  localparam int WS = 3;

  logic        tb_CLK = 1'b0;
  logic        wb_rst = 1'b1;
  logic        wbs_cyc = 1'b0, wbs_stb = 1'b0, wbs_we = 1'b0;
  logic [3:0]  wbs_sel = 4'h0;
  logic [31:0] wbs_adr = '0, wbs_dat_w = '0;
  logic        wbs_ack;
  logic [31:0] wbs_dat_r;
  logic [31:0] tx_dat;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] rx_dat = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        irq;

  int          n_cmp = 0;
  int          n_err = 0;
  int          last_lat;
  logic [31:0] rdata;
  logic        ack_seen;

  wb_mailbox_subordinate #(.DEPTH(8), .WAIT_STATES(WS)) dut (
    .wb_clk_i  (tb_CLK),
    .wb_rst_i  (wb_rst),
    .wbs_cyc_i (wbs_cyc),
    .wbs_stb_i (wbs_stb),
    .wbs_we_i  (wbs_we),
    .wbs_sel_i (wbs_sel),
    .wbs_adr_i (wbs_adr),
    .wbs_dat_i (wbs_dat_w),
    .wbs_ack_o (wbs_ack),
    .wbs_dat_o (wbs_dat_r),
    .tx_dat_o  (tx_dat),
    .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready),
    .rx_dat_i  (rx_dat),
    .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready),
    .irq_o     (irq)
  );

  always #5 tb_CLK = ~tb_CLK;

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One bus transfer; returns read data and records the ack latency in cycles
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output logic [31:0] rd);
    int  n;
    bit  got;
    @(negedge tb_CLK);
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we;
    wbs_adr = adr; wbs_sel = sel; wbs_dat_w = dat;
    n = 0; got = 1'b0; rd = '0;
    while (!got && n < 40) begin
      @(negedge tb_CLK);
      n++;
      if (wbs_ack === 1'b1) begin
        got = 1'b1;
        rd  = wbs_dat_r;
      end
    end
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    last_lat = n;
    if (!got) check_val("ack_timeout", {31'b0, got}, 32'd1);
    $display("wb %s adr=%02h sel=%h wdat=%08h rdat=%08h lat=%0d",
             we ? "WR" : "RD", adr[7:0], sel, dat, rd, n);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, sel, dat, dummy);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] rd);
    wb_xfer(1'b0, adr, 4'hF, 32'h0, rd);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge tb_CLK);
    check_val("rst_ack", {31'b0, wbs_ack}, 32'd0);
    check_val("rst_dat", wbs_dat_r, 32'h0);
    check_val("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check_val("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    check_val("rst_irq", {31'b0, irq}, 32'd0);
    wb_rst = 1'b0;
    @(negedge tb_CLK);
    check_val("rx_ready_after_rst", {31'b0, rx_ready}, 32'd1);

    // SCRATCH byte-masked write, latency and single-cycle ack
    wb_write(32'h10, 4'hF, 32'h1234_5678);
    check_val("ack_latency", last_lat, WS + 1);
    wb_write(32'h10, 4'b0011, 32'hAAAA_AAAA);
    wb_read(32'h10, rdata);
    check_val("scratch_masked", rdata, 32'h1234_AAAA);
    @(negedge tb_CLK);
    check_val("ack_one_cycle", {31'b0, wbs_ack}, 32'd0);

    // TX push and drain
    wb_write(32'h00, 4'hF, 32'hDEAD_BEEF);
    wb_write(32'h00, 4'hF, 32'h00C0_FFEE);
    wb_read(32'h08, rdata);
    check_val("status_tx2", rdata, 32'h0008_0002);
    check_val("tx_head", tx_dat, 32'hDEAD_BEEF);
    @(negedge tb_CLK);
    tx_ready = 1'b1;
    check_val("tx_out0", tx_dat, 32'hDEAD_BEEF);
    @(negedge tb_CLK);
    check_val("tx_out1", tx_dat, 32'h00C0_FFEE);
    check_val("tx_valid1", {31'b0, tx_valid}, 32'd1);
    @(negedge tb_CLK);
    tx_ready = 1'b0;
    check_val("tx_drained", {31'b0, tx_valid}, 32'd0);

    // RX fill to full, refused 9th word, drain with underflow
    for (int i = 1; i <= 8; i++) begin
      @(negedge tb_CLK);
      rx_valid = 1'b1;
      rx_dat   = 32'(i);
      check_val("rx_ready_fill", {31'b0, rx_ready}, 32'd1);
    end
    @(negedge tb_CLK);
    check_val("rx_ready_full", {31'b0, rx_ready}, 32'd0);
    rx_dat = 32'd9;
    @(negedge tb_CLK);
    rx_valid = 1'b0;
    check_val("irq_disabled", {31'b0, irq}, 32'd0);
    wb_read(32'h08, rdata);
    check_val("status_rx_full", rdata, 32'h0006_0800);
    for (int i = 1; i <= 9; i++) begin
      wb_read(32'h04, rdata);
      check_val("rx_pop", rdata, (i == 9) ? 32'h0 : 32'(i));
    end
    wb_read(32'h08, rdata);
    check_val("status_rx_unf", rdata, 32'h002A_0000);

    // TX overflow, sticky clear, flush
    for (int i = 0; i < 8; i++) wb_write(32'h00, 4'hF, 32'h100 + 32'(i));
    wb_read(32'h08, rdata);
    check_val("status_tx_full", rdata, 32'h0029_0008);
    wb_write(32'h00, 4'hF, 32'h55);
    check_val("ovf_ack_latency", last_lat, WS + 1);
    wb_read(32'h08, rdata);
    check_val("status_tx_ovf", rdata, 32'h0039_0008);
    wb_write(32'h0C, 4'hF, 32'h8);
    wb_read(32'h08, rdata);
    check_val("status_clr_sticky", rdata, 32'h0009_0008);
    check_val("tx_head_kept", tx_dat, 32'h100);
    wb_write(32'h0C, 4'hF, 32'h1);
    wb_read(32'h08, rdata);
    check_val("status_tx_flush", rdata, 32'h000A_0000);

    // Abort by dropping cyc in the 2nd wait cycle
    @(negedge tb_CLK);
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1;
    wbs_adr = 32'h00; wbs_sel = 4'hF; wbs_dat_w = 32'h77;
    ack_seen = 1'b0;
    @(negedge tb_CLK);
    ack_seen |= wbs_ack;
    @(negedge tb_CLK);
    ack_seen |= wbs_ack;
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    repeat (6) begin
      @(negedge tb_CLK);
      ack_seen |= wbs_ack;
    end
    $display("wb WR adr=00 wdat=00000077 aborted");
    check_val("abort_no_ack", {31'b0, ack_seen}, 32'd0);
    check_val("abort_tx_valid", {31'b0, tx_valid}, 32'd0);
    wb_read(32'h08, rdata);
    check_val("abort_status", rdata, 32'h000A_0000);

    // Reset during WAIT
    wb_write(32'h00, 4'hF, 32'h99);
    wb_write(32'h0C, 4'hF, 32'h4);
    @(negedge tb_CLK);
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1;
    wbs_adr = 32'h00; wbs_sel = 4'hF; wbs_dat_w = 32'hAB;
    ack_seen = 1'b0;
    @(negedge tb_CLK);
    ack_seen |= wbs_ack;
    wb_rst = 1'b1;
    @(negedge tb_CLK);
    ack_seen |= wbs_ack;
    wb_rst = 1'b0;
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    repeat (6) begin
      @(negedge tb_CLK);
      ack_seen |= wbs_ack;
    end
    $display("wb WR adr=00 wdat=000000ab reset mid-wait");
    check_val("rst_wait_no_ack", {31'b0, ack_seen}, 32'd0);
    wb_read(32'h08, rdata);
    check_val("rst_wait_status", rdata, 32'h000A_0000);
    wb_read(32'h0C, rdata);
    check_val("rst_wait_ctrl", rdata, 32'h0);

    // Interrupt on pending RX, cleared by rx_flush
    wb_write(32'h0C, 4'hF, 32'h4);
    @(negedge tb_CLK);
    rx_valid = 1'b1;
    rx_dat   = 32'h3C;
    @(negedge tb_CLK);
    rx_valid = 1'b0;
    check_val("irq_lag", {31'b0, irq}, 32'd0);
    @(negedge tb_CLK);
    check_val("irq_rise", {31'b0, irq}, 32'd1);
    wb_write(32'h0C, 4'hF, 32'h6);
    check_val("irq_still_high", {31'b0, irq}, 32'd1);
    @(negedge tb_CLK);
    check_val("irq_fall", {31'b0, irq}, 32'd0);
    wb_read(32'h08, rdata);
    check_val("status_rx_flushed", rdata, 32'h000A_0000);
    wb_read(32'h0C, rdata);
    check_val("ctrl_readback", rdata, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
